muldiv_sequencer: RTL

- Multi-cycle controller and iterative datapath for the EX-stage multiply/divide and HI/LO register pair.
- Accepts decoded ALU signals from ALU control (mult 4'b1101, div 4'b1010, mfhi 4'b1011, mflo 4'b1100).
- Runs a WIDTH-iteration shift-add multiply or restoring divide, owns HI/LO, and raises a pipeline stall for structural and read-after-write hazards on HI/LO.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared ALU signal codes and sequencer state type
package muldiv_pkg;

    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1010;
    localparam logic [3:0] ALU_MFHI = 4'b1011;
    localparam logic [3:0] ALU_MFLO = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] sig);
        return (sig == ALU_MULT) || (sig == ALU_DIV);
    endfunction

    function automatic logic is_hilo_user(input logic [3:0] sig);
        return is_muldiv(sig) || (sig == ALU_MFHI) || (sig == ALU_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add or shift-subtract-restore iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mq_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
        shifted = {acc, mq[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // when the subtraction fits, the difference is below the divisor and needs no top bit
        rem_sub = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            acc_next = fits ? rem_sub : shifted[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], fits};
        end else begin
            acc_next = sum[WIDTH:1];
            mq_next  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed mult/div sequencer owning HI/LO with hazard stall
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [3:0]       ex_alu_signal,
    input  logic             kill,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] mf_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_acc, step_mq;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic               start;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .mq       (mq_q),
        .operand  (opnd_q),
        .acc_next (step_acc),
        .mq_next  (step_mq)
    );

    always_comb begin
        a_mag    = op_a[WIDTH-1] ? -op_a : op_a;
        b_mag    = op_b[WIDTH-1] ? -op_b : op_b;
        start    = ex_valid & is_muldiv(ex_alu_signal) & ~kill;
        prod     = {acc_q, mq_q};
        prod_fix = neg_res_q ? -prod : prod;

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = (ex_alu_signal == ALU_DIV);
                    cnt_d    = '0;
                    if (is_div_d && (op_b == '0)) begin
                        // divide by zero skips iteration; flags cleared so DONE writes raw values
                        acc_d     = op_a;
                        mq_d      = '1;
                        opnd_d    = '0;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        acc_d     = '0;
                        mq_d      = is_div_d ? a_mag : b_mag;
                        opnd_d    = is_div_d ? b_mag : a_mag;
                        neg_res_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_rem_d = op_a[WIDTH-1];
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    mq_d  = step_mq;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!kill) begin
                    if (is_div_q) begin
                        hi_d = neg_rem_q ? -acc_q : acc_q;
                        lo_d = neg_res_q ? -mq_q : mq_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        stall     = busy & ex_valid & is_hilo_user(ex_alu_signal);
        mf_result = '0;
        if (!busy) begin
            if (ex_alu_signal == ALU_MFHI) begin
                mf_result = hi_q;
            end else if (ex_alu_signal == ALU_MFLO) begin
                mf_result = lo_q;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
